// File: rtl/alu_share_arbiter_if.sv
// Request/response channels for two ALU clients plus the shared ALU bus.
// The arbiter uses the slave modport. The requesters, the ALU and the bench use master.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;

  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    input  rsp0_ready, rsp1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    output rsp1_valid, rsp1_result, rsp1_zero,
    output alu_op, alu_a, alu_b,
    input  alu_result, alu_zero,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    output rsp0_ready, rsp1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp1_valid, rsp1_result, rsp1_zero,
    input  alu_op, alu_a, alu_b,
    output alu_result, alu_zero,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational ALU between two requesters.
// An accepted operation is driven to the ALU for one cycle from registered operands.
// The result is then captured and held on the winner's response channel until that requester takes it.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  alu_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [OP_W-1:0]  op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             zero_r;
  logic             id_r;
  logic             rr_ptr;

  logic             any_valid;
  logic             grant;
  logic             accept;
  logic             rsp_take;

  // Grant: a lone requester always wins. On a tie the pointer decides.
  // Ready is additionally gated by reset_n so nothing is offered while reset is held.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant     = (bus.req0_valid & bus.req1_valid) ? rr_ptr : bus.req1_valid;
    accept    = (state == IDLE) & any_valid & reset_n;
    rsp_take  = (state == RESP) & (id_r ? bus.rsp1_ready : bus.rsp0_ready);
  end

  assign bus.req0_ready = accept & ~grant;
  assign bus.req1_ready = accept & grant;

  // State register. Reset aborts any transaction in flight.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a single ALU cycle, then wait in RESP until the winner takes the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch on accept and result capture at the end of EXEC.
  // The pointer flips to favour the requester that just lost.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      id_r   <= 1'b0;
      rr_ptr <= 1'b0;
      res_r  <= '0;
      zero_r <= 1'b0;
    end else begin
      if (accept) begin
        op_r   <= grant ? bus.req1_op : bus.req0_op;
        a_r    <= grant ? bus.req1_a  : bus.req0_a;
        b_r    <= grant ? bus.req1_b  : bus.req0_b;
        id_r   <= grant;
        rr_ptr <= ~grant;
      end
      if (state == EXEC) begin
        res_r  <= bus.alu_result;
        zero_r <= bus.alu_zero;
      end
    end
  end

  assign bus.alu_op = op_r;
  assign bus.alu_a  = a_r;
  assign bus.alu_b  = b_r;

  assign bus.rsp0_valid  = (state == RESP) & ~id_r;
  assign bus.rsp1_valid  = (state == RESP) & id_r;
  assign bus.rsp0_result = bus.rsp0_valid ? res_r : '0;
  assign bus.rsp1_result = bus.rsp1_valid ? res_r : '0;
  assign bus.rsp0_zero   = bus.rsp0_valid & zero_r;
  assign bus.rsp1_zero   = bus.rsp1_valid & zero_r;

  assign bus.busy = (state != IDLE);

endmodule
